key_pulser: RTL and testbench
=============================

# key_pulser

Console key front end: synchronizes and debounces NKEYS asynchronous front-panel key contacts and turns an accepted press into a single one-clock pulse. That pulse is suitable for starting the fixed and latched delay chains (e.g. the 5 ms and 100 µs key-manual delays). It arbitrates so only one key is serviced at a time, and optionally auto-repeats the pulse while the key is held. Clock is the 50 MHz system clock (20 ns per cycle).

## Interface
- NKEYS, 8: number of key inputs.
- DEBOUNCE, 250000: cycles a key must stay stable to be accepted as pressed or released (5 ms). Must be ≥ 2.
- REPEAT, 12500000: repeat interval counter limit in cycles (250 ms). Must be ≥ 2.
- Reset is reset, asynchronous, active-high; clock is clk.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- keys  in  NKEYS  raw, asynchronous, bounce-prone key contacts; 1 = pressed.
- rpt_en  in  1  synchronous level; enables auto-repeat while the selected key is held.
- kp  out  1  key pulse; high for exactly one clock per accepted press or repeat.
- kl  out  1  key level; high whenever the block is not IDLE.
- sel  out  NKEYS  one-hot identity of the key being serviced; all-zero in IDLE.

## Operation
- Synchronizer:
  - Two flip-flops per key produce s[NKEYS-1:0].
  - Nothing downstream reads keys directly.
- State machine: IDLE, DB_PRESS, FIRE, HELD, DB_REL.
- One shared counter cnt, width $clog2(max(DEBOUNCE,REPEAT))+1.
- IDLE:
  - If s≠0, load sel with the lowest-index set bit of s, set cnt=0, go DB_PRESS.
  - Otherwise stay.
- DB_PRESS:
  - If (s & sel)==0 (bounce or release), clear sel and go IDLE.
  - Else if cnt==DEBOUNCE-1, go FIRE.
  - Else cnt++.
- FIRE: lasts one cycle; set cnt=0 and go HELD.
- HELD:
  - If (s & sel)==0, set cnt=0 and go DB_REL.
  - Else if !rpt_en, set cnt=0.
  - Else if cnt==REPEAT-1, go FIRE.
  - Else cnt++.
- DB_REL:
  - If (s & sel)≠0 (bounce), set cnt=0 and stay.
  - Else if cnt==DEBOUNCE-1, clear sel and go IDLE.
  - Else cnt++.
- Outputs:
  - kp = (state==FIRE), decoded from registered state with no combinational path from inputs.
  - kl = (state≠IDLE).
  - sel is registered.
- Arbitration:
  - Keys other than sel are ignored in every non-IDLE state.
  - After the return to IDLE, a still-held other key is captured on the next cycle and goes through the full DEBOUNCE again.
- Reset at any time:
  - Synchronizer flops, cnt and sel go to 0; state goes to IDLE.
  - kp=0, kl=0, sel=0 immediately and asynchronously.
  - An in-progress debounce or repeat is abandoned, and no pulse is emitted on reset release.

## Timing
- Key latency:
  - A key first sampled high at edge k reaches s at edge k+1.
  - IDLE moves to DB_PRESS at edge k+2.
  - FIRE is entered at edge k+2+DEBOUNCE, so kp is high during cycle k+2+DEBOUNCE only.
- kl rises at edge k+2.
- Repeat with rpt_en held high: successive kp pulses are exactly REPEAT+1 cycles apart (rising edge to rising edge).
- Deasserting rpt_en in HELD suppresses further pulses. Reasserting it restarts counting from 0: the next kp comes REPEAT cycles later, entering FIRE on the edge after cnt reaches REPEAT-1.
- Release latency:
  - If the key is released (s falls) at edge r, HELD moves to DB_REL at edge r+1.
  - IDLE is reached at edge r+1+DEBOUNCE, where kl and sel drop.
- A bounce in DB_PRESS shorter than DEBOUNCE produces no kp.
- A bounce in DB_REL restarts the release window and produces no second kp.
- kp is never asserted on two consecutive cycles.

## Test plan
All scenarios use NKEYS=4, DEBOUNCE=4, REPEAT=6.

- **Reset:** reset pulse mid-DB_PRESS with keys=0001 held → kp/kl/sel=0 immediately; after release, kp at 2+4 cycles past the first sample edge and no earlier pulse.
- **Clean press:** keys=0100 held for 20 cycles, rpt_en=0 → kl rises at edge 2, sel=0100, exactly one kp at edge 6; kl falls 1+4 cycles after s falls.
- **Bounce:** keys=0001 toggling 1,1,0,1,1,1,1,1 → first short burst yields no kp; kp occurs 6 cycles after the last 0→1 sample.
- **Repeat:** keys=0010 held for 30 cycles with rpt_en=1 → kp at edges 6, 13, 20, 27; drop rpt_en at edge 22 → the kp at 27 is absent.
- **Arbitration:** keys=1000 then keys=1001 two cycles later → sel=1000 and one kp; release bit 3 → after DB_REL, sel=0001 and a second kp follows DEBOUNCE+1 cycles after IDLE.
- **Simultaneous keys:** keys=0110 asserted together → sel=0010 (lowest index) and a single kp.

Source files
------------

// File: rtl/key_pulser.sv
// Key front end: synchronizes and debounces raw key contacts, services one key at a time and
// emits a one-clock pulse per accepted press, with optional auto-repeat while the key is held.
module key_pulser #(
  parameter int unsigned NKEYS    = 8,
  parameter int unsigned DEBOUNCE = 250000,
  parameter int unsigned REPEAT   = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys,
  input  logic             rpt_en,
  output logic             kp,
  output logic             kl,
  output logic [NKEYS-1:0] sel
);

  localparam int unsigned CntMax = (DEBOUNCE > REPEAT) ? DEBOUNCE : REPEAT;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic [CntW-1:0] DbLast  = CntW'(DEBOUNCE - 1);
  localparam logic [CntW-1:0] RptLast = CntW'(REPEAT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDbPress,
    StFire,
    StHeld,
    StDbRel
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [NKEYS-1:0]  sel_q, sel_d;
  logic [NKEYS-1:0]  sync1_q, s_q;
  logic [NKEYS-1:0]  low_bit;
  logic              hit;

  // Two-flop synchronizer; nothing below looks at keys directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= keys;
      s_q     <= sync1_q;
    end
  end

  // Descending scan so the lowest-index set bit is the one that sticks.
  always_comb begin
    low_bit = '0;
    for (int i = int'(NKEYS) - 1; i >= 0; i--) begin
      if (s_q[i]) begin
        low_bit    = '0;
        low_bit[i] = 1'b1;
      end
    end
  end

  assign hit = |(s_q & sel_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (|s_q) begin
          sel_d   = low_bit;
          cnt_d   = '0;
          state_d = StDbPress;
        end
      end
      StDbPress: begin
        if (!hit) begin
          sel_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == DbLast) begin
          state_d = StFire;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFire: begin
        cnt_d   = '0;
        state_d = StHeld;
      end
      StHeld: begin
        if (!hit) begin
          cnt_d   = '0;
          state_d = StDbRel;
        end else if (!rpt_en) begin
          cnt_d = '0;
        end else if (cnt_q == RptLast) begin
          state_d = StFire;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDbRel: begin
        // Any contact during the release window restarts it.
        if (hit) begin
          cnt_d = '0;
        end else if (cnt_q == DbLast) begin
          sel_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        sel_d   = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  assign kp  = (state_q == StFire);
  assign kl  = (state_q != StIdle);
  assign sel = sel_q;

endmodule

// File: tb/tb_key_pulser.sv
// Directed, table-driven bench for key_pulser with NKEYS=4, DEBOUNCE=4, REPEAT=6.
module tb_key_pulser;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys;
  logic       rpt_en;
  logic       kp;
  logic       kl;
  logic [3:0] sel;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] keys;
    logic       rpt;
    logic       kp;
    logic       kl;
    logic [3:0] sel;
  } vec_t;

  vec_t tbl[$];

  key_pulser #(
    .NKEYS   (4),
    .DEBOUNCE(4),
    .REPEAT  (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .keys  (keys),
    .rpt_en(rpt_en),
    .kp    (kp),
    .kl    (kl),
    .sel   (sel)
  );

  always #5 clk = ~clk;

  // Append n identical rows: inputs applied before an edge, outputs expected just after it.
  task automatic add(input logic [3:0] k, input logic r, input logic p, input logic l,
                     input logic [3:0] s, input int n);
    vec_t v;
    v.keys = k;
    v.rpt  = r;
    v.kp   = p;
    v.kl   = l;
    v.sel  = s;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got kp=%b kl=%b sel=%b, want kp=%b kl=%b sel=%b", name,
               got[5], got[4], got[3:0], want[5], want[4], want[3:0]);
    end
  endtask

  task automatic run(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      keys   = tbl[i].keys;
      rpt_en = tbl[i].rpt;
      @(posedge clk);
      #1;
      check($sformatf("%s edge %0d", name, i + 1), {kp, kl, sel},
            {tbl[i].kp, tbl[i].kl, tbl[i].sel});
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    keys   = '0;
    rpt_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    keys   = '0;
    rpt_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {kp, kl, sel}, 6'b0);
    reset = 1'b0;

    // Reset in the middle of DB_PRESS, then a full press after release.
    keys = 4'b0001;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("pre-reset db_press", {kp, kl, sel}, {1'b0, 1'b1, 4'b0001});
    #2;
    reset = 1'b1;
    #1;
    check("async reset", {kp, kl, sel}, 6'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    add(4'b0001, 0, 0, 0, 4'b0000, 2);
    add(4'b0001, 0, 0, 1, 4'b0001, 4);
    add(4'b0001, 0, 1, 1, 4'b0001, 1);
    add(4'b0001, 0, 0, 1, 4'b0001, 3);
    run("after_reset");

    do_reset();
    add(4'b0100, 0, 0, 0, 4'b0000, 2);
    add(4'b0100, 0, 0, 1, 4'b0100, 4);
    add(4'b0100, 0, 1, 1, 4'b0100, 1);
    add(4'b0100, 0, 0, 1, 4'b0100, 13);
    add(4'b0000, 0, 0, 1, 4'b0100, 6);
    add(4'b0000, 0, 0, 0, 4'b0000, 4);
    run("clean");

    do_reset();
    add(4'b0001, 0, 0, 0, 4'b0000, 2);
    add(4'b0000, 0, 0, 1, 4'b0001, 1);
    add(4'b0001, 0, 0, 1, 4'b0001, 1);
    add(4'b0001, 0, 0, 0, 4'b0000, 1);
    add(4'b0001, 0, 0, 1, 4'b0001, 4);
    add(4'b0001, 0, 1, 1, 4'b0001, 1);
    add(4'b0001, 0, 0, 1, 4'b0001, 4);
    run("bounce");

    do_reset();
    add(4'b0010, 1, 0, 0, 4'b0000, 2);
    add(4'b0010, 1, 0, 1, 4'b0010, 4);
    add(4'b0010, 1, 1, 1, 4'b0010, 1);
    add(4'b0010, 1, 0, 1, 4'b0010, 6);
    add(4'b0010, 1, 1, 1, 4'b0010, 1);
    add(4'b0010, 1, 0, 1, 4'b0010, 6);
    add(4'b0010, 1, 1, 1, 4'b0010, 1);
    add(4'b0010, 1, 0, 1, 4'b0010, 1);
    add(4'b0010, 0, 0, 1, 4'b0010, 10);
    add(4'b0010, 1, 0, 1, 4'b0010, 5);
    add(4'b0010, 1, 1, 1, 4'b0010, 1);
    add(4'b0010, 1, 0, 1, 4'b0010, 2);
    run("repeat");

    do_reset();
    add(4'b1000, 0, 0, 0, 4'b0000, 2);
    add(4'b1001, 0, 0, 1, 4'b1000, 4);
    add(4'b1001, 0, 1, 1, 4'b1000, 1);
    add(4'b1001, 0, 0, 1, 4'b1000, 4);
    add(4'b0001, 0, 0, 1, 4'b1000, 6);
    add(4'b0001, 0, 0, 0, 4'b0000, 1);
    add(4'b0001, 0, 0, 1, 4'b0001, 4);
    add(4'b0001, 0, 1, 1, 4'b0001, 1);
    add(4'b0001, 0, 0, 1, 4'b0001, 3);
    run("arbitration");

    do_reset();
    add(4'b0110, 0, 0, 0, 4'b0000, 2);
    add(4'b0110, 0, 0, 1, 4'b0010, 4);
    add(4'b0110, 0, 1, 1, 4'b0010, 1);
    add(4'b0110, 0, 0, 1, 4'b0010, 7);
    run("simultaneous");

    do_reset();
    add(4'b0100, 0, 0, 0, 4'b0000, 2);
    add(4'b0100, 0, 0, 1, 4'b0100, 4);
    add(4'b0100, 0, 1, 1, 4'b0100, 1);
    add(4'b0100, 0, 0, 1, 4'b0100, 3);
    add(4'b0000, 0, 0, 1, 4'b0100, 2);
    add(4'b0100, 0, 0, 1, 4'b0100, 1);
    add(4'b0000, 0, 0, 1, 4'b0100, 5);
    add(4'b0000, 0, 0, 0, 4'b0000, 7);
    run("release_bounce");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
